// File: rtl/fp_round_pkg.sv
// Shared rounding-mode encoding and increment decision for the FP rounding datapath.
package fp_round_pkg;

    typedef enum logic [1:0] {
        RND_RNE = 2'd0,
        RND_RTZ = 2'd1,
        RND_POS = 2'd2,
        RND_NEG = 2'd3
    } rnd_mode_e;

    // Decide whether the kept mantissa must be bumped by one ulp.
    function automatic logic round_inc(
        input rnd_mode_e mode,
        input logic      sign,
        input logic      lsb,
        input logic      g,
        input logic      s
    );
        case (mode)
            RND_RNE: return g & (s | lsb);
            RND_RTZ: return 1'b0;
            RND_POS: return !sign & (g | s);
            RND_NEG: return sign & (g | s);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/round_decision_stage.sv
// Stage-1 combinational logic: split significand into kept/guard/sticky and decide increment.
module round_decision_stage
    import fp_round_pkg::*;
#(
    parameter int unsigned IN_W   = 32,
    parameter int unsigned MANT_W = 23,
    parameter int unsigned EXP_W  = 8
) (
    input  logic              sign,
    input  logic [EXP_W-1:0]  exp,
    input  logic [IN_W-1:0]   data,
    input  logic [1:0]        mode,
    output logic [MANT_W-1:0] kept_c,
    output logic              inc_c,
    output logic              inexact_c
);

    localparam int unsigned G_POS = IN_W - 2 - MANT_W;

    logic g;
    logic s;
    logic special;
    logic unused_hidden;

    assign kept_c        = data[IN_W-2 -: MANT_W];
    assign g             = data[G_POS];
    assign unused_hidden = data[IN_W-1];

    // Sticky collapses everything below the guard bit; absent when guard is the LSB.
    generate
        if (G_POS == 0) begin : g_no_sticky
            assign s = 1'b0;
        end else begin : g_sticky
            assign s = |data[G_POS-1:0];
        end
    endgenerate

    // Inf/NaN operands pass through untouched.
    assign special   = &exp;
    assign inc_c     = special ? 1'b0 : round_inc(rnd_mode_e'(mode), sign, kept_c[0], g, s);
    assign inexact_c = !special & (g | s);

endmodule

// File: rtl/pipelined_rounding_unit.sv
// Two-stage valid/ready rounding unit: stage 1 registers the round decision,
// stage 2 applies the increment, carries into the exponent and flags overflow.
module pipelined_rounding_unit
    import fp_round_pkg::*;
#(
    parameter int unsigned IN_W   = 32,
    parameter int unsigned MANT_W = 23,
    parameter int unsigned EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [IN_W-1:0]   in_data,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic              out_inexact,
    output logic              out_overflow
);

    localparam int unsigned SUM_W = MANT_W + 1;

    logic [MANT_W-1:0] kept_c;
    logic              inc_c;
    logic              inexact_c;

    logic              s1_valid;
    logic              s1_sign;
    logic [EXP_W-1:0]  s1_exp;
    logic [MANT_W-1:0] s1_kept;
    logic              s1_inc;
    logic              s1_inexact;

    logic              s2_ready;
    logic [SUM_W-1:0]  sum_c;
    logic [EXP_W-1:0]  s2_exp_c;
    logic [MANT_W-1:0] s2_mant_c;
    logic              s2_ovf_c;

    round_decision_stage #(
        .IN_W   (IN_W),
        .MANT_W (MANT_W),
        .EXP_W  (EXP_W)
    ) u_decision (
        .sign      (in_sign),
        .exp       (in_exp),
        .data      (in_data),
        .mode      (in_mode),
        .kept_c    (kept_c),
        .inc_c     (inc_c),
        .inexact_c (inexact_c)
    );

    // Ready chain depends only on registered valids and downstream ready.
    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;

    // Stage 1 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_exp     <= '0;
            s1_kept    <= '0;
            s1_inc     <= 1'b0;
            s1_inexact <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign    <= in_sign;
                s1_exp     <= in_exp;
                s1_kept    <= kept_c;
                s1_inc     <= inc_c;
                s1_inexact <= inexact_c;
            end
        end
    end

    // Increment; a mantissa carry bumps the exponent, and reaching all-ones means infinity.
    always_comb begin
        sum_c     = {1'b0, s1_kept} + SUM_W'(s1_inc);
        s2_exp_c  = s1_exp;
        s2_mant_c = sum_c[MANT_W-1:0];
        s2_ovf_c  = 1'b0;
        if (sum_c[MANT_W]) begin
            s2_exp_c  = s1_exp + EXP_W'(1);
            s2_mant_c = '0;
            s2_ovf_c  = &s2_exp_c;
        end
    end

    // Stage 2 register drives the outputs directly and holds them under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_sign     <= 1'b0;
            out_exp      <= '0;
            out_mant     <= '0;
            out_inexact  <= 1'b0;
            out_overflow <= 1'b0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sign     <= s1_sign;
                out_exp      <= s2_exp_c;
                out_mant     <= s2_mant_c;
                out_inexact  <= s1_inexact;
                out_overflow <= s2_ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_rounding_unit.sv
// Directed bench for pipelined_rounding_unit: rounding modes, carry/overflow,
// backpressure ordering and mid-flight reset.
module tb_pipelined_rounding_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [31:0] in_data;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [22:0] out_mant;
    logic        out_inexact;
    logic        out_overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    pipelined_rounding_unit #(
        .IN_W   (32),
        .MANT_W (23),
        .EXP_W  (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_data      (in_data),
        .in_mode      (in_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sign     (out_sign),
        .out_exp      (out_exp),
        .out_mant     (out_mant),
        .out_inexact  (out_inexact),
        .out_overflow (out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Send one transaction with an open sink and check the result and its latency.
    task automatic send_vec(input string tag, input logic [31:0] data, input logic [7:0] exp,
                            input logic sign, input logic [1:0] mode, input logic [22:0] e_mant,
                            input logic [7:0] e_exp, input logic e_inx, input logic e_ovf);
        int cyc;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = data;
        in_exp    = exp;
        in_sign   = sign;
        in_mode   = mode;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) in_valid = 1'b0;
        end while (!out_valid && cyc < 10);
        check({tag, ".latency"}, 32'(cyc), 32'd2);
        check({tag, ".mant"}, 32'(out_mant), 32'(e_mant));
        check({tag, ".exp"}, 32'(out_exp), 32'(e_exp));
        check({tag, ".inexact"}, 32'(out_inexact), 32'(e_inx));
        check({tag, ".overflow"}, 32'(out_overflow), 32'(e_ovf));
        check({tag, ".sign"}, 32'(out_sign), 32'(sign));
    endtask

    initial begin
        int nxt;
        int acc;
        int got_n;
        int first_cyc;
        int last_cyc;
        logic stale;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_data   = '0;
        in_mode   = '0;
        out_ready = 1'b1;
        #1;
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.out_mant", 32'(out_mant), 32'd0);
        check("reset.out_exp", 32'(out_exp), 32'd0);
        check("reset.flags", {30'd0, out_inexact, out_overflow}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset.in_ready", 32'(in_ready), 32'd1);

        // tag, data, exp, sign, mode, mant, exp, inexact, overflow
        send_vec("rne_tie_even", 32'h8000_0080, 8'h10, 1'b0, 2'd0, 23'h000000, 8'h10, 1'b1, 1'b0);
        send_vec("rne_tie_odd",  32'h8000_0180, 8'h10, 1'b0, 2'd0, 23'h000002, 8'h10, 1'b1, 1'b0);
        send_vec("rtz_neg",      32'h8000_0001, 8'h10, 1'b1, 2'd1, 23'h000000, 8'h10, 1'b1, 1'b0);
        send_vec("pos_neg",      32'h8000_0001, 8'h10, 1'b1, 2'd2, 23'h000000, 8'h10, 1'b1, 1'b0);
        send_vec("neg_neg",      32'h8000_0001, 8'h10, 1'b1, 2'd3, 23'h000001, 8'h10, 1'b1, 1'b0);
        send_vec("pos_pos",      32'h8000_0001, 8'h10, 1'b0, 2'd2, 23'h000001, 8'h10, 1'b1, 1'b0);
        send_vec("carry",        32'hFFFF_FFFF, 8'h10, 1'b0, 2'd0, 23'h000000, 8'h11, 1'b1, 1'b0);
        send_vec("overflow",     32'hFFFF_FFFF, 8'hFE, 1'b0, 2'd0, 23'h000000, 8'hFF, 1'b1, 1'b1);
        send_vec("special",      32'hFFFF_FFFF, 8'hFF, 1'b0, 2'd0, 23'h7FFFFF, 8'hFF, 1'b0, 1'b0);
        send_vec("zero",         32'h0000_0000, 8'h33, 1'b0, 2'd0, 23'h000000, 8'h33, 1'b0, 1'b0);
        send_vec("exact",        32'h8123_4500, 8'h40, 1'b1, 2'd3, 23'h012345, 8'h40, 1'b0, 1'b0);

        // Backpressure: 5 stalled cycles, then drain; item k yields mant k+1, exp 0x20+k.
        nxt       = 0;
        acc       = 0;
        got_n     = 0;
        first_cyc = -1;
        last_cyc  = -1;
        for (int c = 0; c < 25 && got_n < 4; c++) begin
            @(negedge clk);
            out_ready = (c >= 5);
            if (nxt < 4) begin
                in_valid = 1'b1;
                in_data  = 32'h8000_0000 | (32'(nxt + 1) << 8);
                in_exp   = 8'(32'h20 + 32'(nxt));
                in_sign  = 1'b0;
                in_mode  = 2'd1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c == 4) begin
                check("bp.accepts", 32'(acc), 32'd2);
                check("bp.in_ready", 32'(in_ready), 32'd0);
            end
            if (!out_ready && out_valid) begin
                check("bp.hold_mant", 32'(out_mant), 32'd1);
                check("bp.hold_exp", 32'(out_exp), 32'h20);
            end
            if (out_valid && out_ready) begin
                check("bp.order_mant", 32'(out_mant), 32'(got_n + 1));
                check("bp.order_exp", 32'(out_exp), 32'h20 + 32'(got_n));
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
                got_n++;
            end
            if (in_valid && in_ready) begin
                nxt++;
                acc++;
            end
        end
        in_valid = 1'b0;
        check("bp.count", 32'(got_n), 32'd4);
        check("bp.span", 32'(last_cyc - first_cyc), 32'd3);

        // Reset with both stages occupied.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h8000_0500;
        in_exp    = 8'h50;
        in_mode   = 2'd1;
        @(negedge clk);
        in_data   = 32'h8000_0600;
        @(negedge clk);
        in_valid  = 1'b0;
        #1;
        check("rst.pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_mant", 32'(out_mant), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        stale     = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        check("rst.no_stale", 32'(stale), 32'd0);
        send_vec("post_rst", 32'h8000_0700, 8'h22, 1'b0, 2'd0, 23'h000007, 8'h22, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipelined_rounding_unit.md
Name: pipelined_rounding_unit

Overview:
- Two-stage, valid/ready pipelined rounding unit for the FP datapath.
- Takes a normalised wide significand plus sign and biased exponent, and produces a rounded MANT_W-bit mantissa.
- Handles all four IEEE rounding modes with full guard/sticky logic, including correct ties-to-even.
- Propagates mantissa carry into the exponent, detects overflow to infinity, and raises an inexact flag.
- Sits between the adder/multiplier normaliser and the result packer.

Parameters:
- IN_W, 32: input significand width. Bit IN_W-1 is the hidden one. Must satisfy IN_W >= MANT_W+2.
- MANT_W, 23: stored mantissa width.
- EXP_W, 8: biased exponent width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input transaction valid.
- in_ready  output  1  unit can accept input.
- in_sign  input  1  operand sign.
- in_exp  input  EXP_W  biased exponent.
- in_data  input  IN_W  normalised significand.
- in_mode  input  2  rounding mode: 0 RNE, 1 RTZ, 2 toward +inf, 3 toward -inf.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_sign  output  1  result sign.
- out_exp  output  EXP_W  result exponent.
- out_mant  output  MANT_W  rounded mantissa.
- out_inexact  output  1  guard or sticky was set.
- out_overflow  output  1  rounding carried exponent to all-ones.

Behaviour:
- Reset (async, rst_n low):
  - s1_valid=0, s2_valid=0, out_valid=0, all data/flag outputs 0.
  - in_ready=1 once rst_n deasserts.
  - In-flight transactions are discarded.
- Handshake: standard valid/ready; a transfer occurs when valid and ready are both high in the same cycle.
  - s2_ready = !s2_valid || out_ready.
  - in_ready = !s1_valid || s2_ready (combinational ready chain; no combinational valid-to-ready path).
  - Latency: 2 cycles from input accept to out_valid with no backpressure. Throughput 1 per cycle.
  - Full stall holds both stages; no drop, no duplication, order preserved.
  - out_* are stable while out_valid=1 and out_ready=0.
- Stage 1 (registered on accept):
  - kept = in_data[IN_W-2 : IN_W-1-MANT_W].
  - G = in_data[IN_W-2-MANT_W].
  - S = OR of in_data[IN_W-3-MANT_W : 0]; S=0 when IN_W == MANT_W+2.
  - Increment decision:
    - RNE: G & (S | kept[0]).
    - RTZ: 0.
    - +inf: !sign & (G|S).
    - -inf: sign & (G|S).
  - inexact = G|S.
  - Special input in_exp all-ones (inf/NaN): increment=0, inexact=0, kept passed unchanged.
- Stage 2 (registered when s2 accepts):
  - sum = {1'b0, kept} + inc, width MANT_W+1.
  - If sum[MANT_W]=1: mant=0, exp=exp+1.
  - If the new exp is all-ones: overflow=1, mant=0 (infinity).
  - Overflow occurs only on increment, so results round toward infinity in all modes that increment.
- Sign passes through unchanged.
- in_mode is sampled per transaction; a mode change between back-to-back inputs affects only the new transaction.
- Zero input (in_data=0) yields mant 0, exp unchanged, inexact 0.

Decomposition:
- Shared package fp_round_pkg holds:
  - rounding mode constants RND_RNE=0, RND_RTZ=1, RND_POS=2, RND_NEG=3;
  - a function computing the increment decision from mode, sign, lsb, G, S.
- One natural sub-module: round_decision_stage (stage 1: field extraction, G/S, increment, inexact). The top holds the stage-2 adder, exponent/overflow logic and both handshake registers.

Test Plan:
- RNE ties (defaults, exp=0x10, sign 0):
  - in_data=0x80000080 -> out_mant=0x000000, inexact=1 (tie, even kept).
  - in_data=0x80000180 -> out_mant=0x000002, inexact=1.
- Modes on in_data=0x80000001, sign 1:
  - RTZ -> mant 0x000000;
  - +inf -> mant 0x000000;
  - -inf -> mant 0x000001.
  - inexact=1 in all three.
- Carry: in_data=0xFFFFFFFF, exp=0x10, RNE -> out_mant=0, out_exp=0x11, inexact=1, overflow=0.
- Overflow and passthrough:
  - exp=0xFE, in_data=0xFFFFFFFF, RNE -> out_exp=0xFF, out_mant=0, overflow=1.
  - Same data with exp=0xFF -> mant 0x7FFFFF, overflow=0, inexact=0.
- Backpressure: stream 4 transactions with out_ready=0 for 5 cycles:
  - in_ready drops after 2 accepts;
  - outputs hold stable;
  - after out_ready=1, all 4 emerge in order, one per cycle, with none lost or duplicated.
- Reset mid-flight: assert rst_n=0 with both stages valid:
  - out_valid=0 immediately (async);
  - after release, in_ready=1, no stale result appears, and the next input emerges 2 cycles after accept.
